// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - shared constants and state encoding for the CORDIC NCO sequencer
package cordic_ctrl_pkg;

  localparam int CORDIC_LATENCY = 20;
  localparam int WF_DEFAULT     = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SYNC      = 3'd2;
  localparam logic [2:0] ST_PHASE_RST = 3'd3;
  localparam logic [2:0] ST_SETTLE    = 3'd4;

  // Channel index width, never narrower than one bit.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - down-counter covering the CORDIC pipeline flush after an update
module settle_timer #(
  parameter int SETTLE = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(SETTLE + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(SETTLE - 1);
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/cordic_nco_sequencer.sv
// rtl/cordic_nco_sequencer.sv - shadowed frequency commit and phase-coherent restart for NUM_RX CORDICs
module cordic_nco_sequencer
  import cordic_ctrl_pkg::*;
#(
  parameter int NUM_RX = 4,
  parameter int WF     = WF_DEFAULT,
  parameter int SETTLE = CORDIC_LATENCY,
  parameter int CHW    = chan_width(NUM_RX)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CHW-1:0]       wr_chan,
  input  logic [WF-1:0]        wr_freq,
  input  logic                 commit,
  input  logic                 sync_req,
  output logic [NUM_RX*WF-1:0] freq_out,
  output logic [NUM_RX-1:0]    nco_reset,
  output logic [NUM_RX-1:0]    data_valid,
  output logic                 busy
);

  logic [2:0]        state;
  logic [WF-1:0]     shadow [NUM_RX];
  logic [NUM_RX-1:0] dirty;
  logic [NUM_RX-1:0] wr_hit;
  logic [NUM_RX-1:0] dirty_now;
  logic              pend_commit;
  logic              pend_sync;
  logic              wr_fire;
  logic              timer_load;
  logic              timer_done;

  assign wr_ready   = (state == ST_IDLE) || (state == ST_SETTLE);
  assign busy       = (state != ST_IDLE);
  assign wr_fire    = wr_valid && wr_ready;
  assign timer_load = (state == ST_LOAD) || (state == ST_PHASE_RST);

  // Out-of-range channel indices match no bit and are silently dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_RX; i++) begin
      if (wr_fire && (wr_chan == CHW'(i))) wr_hit[i] = 1'b1;
    end
  end

  assign dirty_now = dirty | wr_hit;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_PHASE_RST;
      dirty       <= '0;
      pend_commit <= 1'b0;
      pend_sync   <= 1'b0;
      freq_out    <= '0;
      nco_reset   <= '1;
      data_valid  <= '0;
      for (int i = 0; i < NUM_RX; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RX; i++) begin
        if (wr_hit[i]) shadow[i] <= wr_freq;
      end
      dirty <= dirty_now;

      case (state)
        ST_IDLE: begin
          if (sync_req || pend_sync) begin
            state <= ST_SYNC;
          end else if (commit || pend_commit) begin
            if (|dirty_now) state <= ST_LOAD;
            else pend_commit <= 1'b0;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < NUM_RX; i++) begin
            if (dirty[i]) begin
              freq_out[i*WF +: WF] <= shadow[i];
              data_valid[i]        <= 1'b0;
            end
          end
          dirty       <= '0;
          pend_commit <= 1'b0;
          state       <= ST_SETTLE;
        end
        ST_SYNC: begin
          for (int i = 0; i < NUM_RX; i++) freq_out[i*WF +: WF] <= shadow[i];
          nco_reset   <= '1;
          data_valid  <= '0;
          dirty       <= '0;
          pend_sync   <= 1'b0;
          pend_commit <= 1'b0;
          state       <= ST_PHASE_RST;
        end
        ST_PHASE_RST: begin
          nco_reset <= '0;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_done) begin
            data_valid <= '1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Requests seen while busy are remembered even if the current state clears them.
      if (state != ST_IDLE) begin
        if (commit)   pend_commit <= 1'b1;
        if (sync_req) pend_sync   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco_sequencer.sv
// tb/tb_cordic_nco_sequencer.sv - scoreboard bench for cordic_nco_sequencer
module tb_cordic_nco_sequencer;

  localparam logic [31:0] FA = 32'h0A3D70A4;
  localparam logic [31:0] FB = 32'h12345678;
  localparam logic [31:0] FC = 32'hFEDCBA98;
  localparam logic [31:0] FD = 32'h00000BEE;
  localparam logic [31:0] FE = 32'h00000001;
  localparam logic [31:0] FG = 32'h80000000;
  localparam logic [31:0] FH = 32'h00005555;
  localparam logic [31:0] Z  = 32'h0;

  logic         clock = 1'b0;
  logic         reset;
  logic         wr_valid, commit, sync_req;
  logic [1:0]   wr_chan;
  logic [31:0]  wr_freq;
  logic         wr_ready, busy;
  logic [127:0] freq_out;
  logic [3:0]   nco_reset, data_valid;

  logic         w2_valid, c2, s2;
  logic [2:0]   w2_chan;
  logic [31:0]  w2_freq;
  logic         wr_ready2, busy2;
  logic [159:0] freq_out2;
  logic [4:0]   nco_reset2, data_valid2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           c;
    logic [127:0] f;
    logic [3:0]   n;
    logic [3:0]   d;
    logic         b;
    logic         w;
  } ev_t;

  ev_t exp_q[$];

  cordic_nco_sequencer #(.NUM_RX(4), .WF(32), .SETTLE(20)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_freq(wr_freq), .commit(commit), .sync_req(sync_req),
    .freq_out(freq_out), .nco_reset(nco_reset), .data_valid(data_valid), .busy(busy)
  );

  cordic_nco_sequencer #(.NUM_RX(5), .WF(32), .SETTLE(3)) dut2 (
    .clock(clock), .reset(reset), .wr_valid(w2_valid), .wr_ready(wr_ready2),
    .wr_chan(w2_chan), .wr_freq(w2_freq), .commit(c2), .sync_req(s2),
    .freq_out(freq_out2), .nco_reset(nco_reset2), .data_valid(data_valid2), .busy(busy2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic ex(input int c, input logic [127:0] f, input logic [3:0] n,
                    input logic [3:0] d, input logic b, input logic w);
    ev_t e;
    e.c = c; e.f = f; e.n = n; e.d = d; e.b = b; e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [31:0] v);
    wr_valid = 1'b1; wr_chan = ch; wr_freq = v;
    step();
    wr_valid = 1'b0;
  endtask

  // Monitor: every change of the observable outputs must match the next queued expectation.
  logic [137:0] prev = 'x;
  always @(negedge clock) begin
    logic [137:0] snap;
    ev_t e;
    snap = {freq_out, nco_reset, data_valid, busy, wr_ready};
    if (snap !== prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", 160'(snap), 160'(prev));
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", 160'(cyc), 160'(e.c));
        chk("freq_out", 160'(freq_out), 160'(e.f));
        chk("nco_reset", 160'(nco_reset), 160'(e.n));
        chk("data_valid", 160'(data_valid), 160'(e.d));
        chk("busy", 160'(busy), 160'(e.b));
        chk("wr_ready", 160'(wr_ready), 160'(e.w));
      end
    end
    prev = snap;
  end

  initial begin
    int k, r;
    reset = 1'b1; wr_valid = 1'b0; commit = 1'b0; sync_req = 1'b0; wr_chan = '0; wr_freq = '0;
    w2_valid = 1'b0; c2 = 1'b0; s2 = 1'b0; w2_chan = '0; w2_freq = '0;

    // Reset behaves as a sync: nco_reset drops one edge after release, data_valid SETTLE later.
    ex(1,  '0, 4'hF, 4'h0, 1'b1, 1'b0);
    ex(3,  '0, 4'h0, 4'h0, 1'b1, 1'b1);
    ex(23, '0, 4'h0, 4'hF, 1'b0, 1'b1);
    step(); step();
    reset = 1'b0;
    wait_until(26);

    // Second instance (5 channels): chan 5 discarded, so its commit is a no-op.
    w2_valid = 1'b1; w2_chan = 3'd5; w2_freq = 32'hDEADBEEF; c2 = 1'b1;
    step();
    w2_valid = 1'b0; c2 = 1'b0;
    step();
    chk("oor_busy", 160'(busy2), 160'(0));
    chk("oor_freq", freq_out2, '0);
    chk("oor_nco", 160'(nco_reset2), 160'(0));
    chk("oor_ready", 160'(wr_ready2), 160'(1));
    w2_valid = 1'b1; w2_chan = 3'd4; w2_freq = 32'h00000001; c2 = 1'b1;
    step();
    w2_valid = 1'b0; c2 = 1'b0;
    step();
    chk("ch4_freq", freq_out2, {32'h1, 128'h0});
    chk("ch4_valid", 160'(data_valid2), 160'(5'b01111));
    chk("ch4_busy", 160'(busy2), 160'(1));
    wait_until(40);

    // Write ch2 then commit.
    do_write(2'd2, FA);
    commit = 1'b1; k = cyc + 1;
    ex(k,      '0,             4'h0, 4'hF,    1'b1, 1'b0);
    ex(k + 1,  {Z, FA, Z, Z},  4'h0, 4'b1011, 1'b1, 1'b1);
    ex(k + 21, {Z, FA, Z, Z},  4'h0, 4'hF,    1'b0, 1'b1);
    step(); commit = 1'b0;
    wait_until(k + 24);

    // Write ch0 and ch3, then sync.
    do_write(2'd0, FB);
    do_write(2'd3, FC);
    sync_req = 1'b1; k = cyc + 1;
    ex(k,      {Z, FA, Z, Z},   4'h0, 4'hF, 1'b1, 1'b0);
    ex(k + 1,  {FC, FA, Z, FB}, 4'hF, 4'h0, 1'b1, 1'b0);
    ex(k + 2,  {FC, FA, Z, FB}, 4'h0, 4'h0, 1'b1, 1'b1);
    ex(k + 22, {FC, FA, Z, FB}, 4'h0, 4'hF, 1'b0, 1'b1);
    step(); sync_req = 1'b0;
    wait_until(k + 25);

    // Commit ch0; during SETTLE write ch1 and commit again -> second LOAD right after IDLE.
    do_write(2'd0, FE);
    commit = 1'b1; k = cyc + 1;
    ex(k,      {FC, FA, Z, FB},  4'h0, 4'hF,    1'b1, 1'b0);
    ex(k + 1,  {FC, FA, Z, FE},  4'h0, 4'b1110, 1'b1, 1'b1);
    ex(k + 21, {FC, FA, Z, FE},  4'h0, 4'hF,    1'b0, 1'b1);
    ex(k + 22, {FC, FA, Z, FE},  4'h0, 4'hF,    1'b1, 1'b0);
    ex(k + 23, {FC, FA, FD, FE}, 4'h0, 4'b1101, 1'b1, 1'b1);
    ex(k + 43, {FC, FA, FD, FE}, 4'h0, 4'hF,    1'b0, 1'b1);
    step(); commit = 1'b0;
    wait_until(k + 4);
    do_write(2'd1, FD);
    commit = 1'b1;
    step(); commit = 1'b0;
    wait_until(k + 46);

    // Commit with nothing dirty: no busy pulse.
    commit = 1'b1;
    step(); commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("noop_busy", 160'(busy), 160'(0));
      step();
    end

    // Write and commit in the same cycle.
    wr_valid = 1'b1; wr_chan = 2'd3; wr_freq = FG; commit = 1'b1; k = cyc + 1;
    ex(k,      {FC, FA, FD, FE}, 4'h0, 4'hF,    1'b1, 1'b0);
    ex(k + 1,  {FG, FA, FD, FE}, 4'h0, 4'b0111, 1'b1, 1'b1);
    ex(k + 21, {FG, FA, FD, FE}, 4'h0, 4'hF,    1'b0, 1'b1);
    step(); wr_valid = 1'b0; commit = 1'b0;
    wait_until(k + 24);

    // Reset during SETTLE with a pending sync: everything returns to reset values, sync dropped.
    do_write(2'd1, FH);
    commit = 1'b1; k = cyc + 1;
    ex(k,     {FG, FA, FD, FE}, 4'h0, 4'hF,    1'b1, 1'b0);
    ex(k + 1, {FG, FA, FH, FE}, 4'h0, 4'b1101, 1'b1, 1'b1);
    step(); commit = 1'b0;
    wait_until(k + 2);
    sync_req = 1'b1;
    step(); sync_req = 1'b0;
    wait_until(k + 5);
    reset = 1'b1; r = k + 6;
    ex(r,      '0, 4'hF, 4'h0, 1'b1, 1'b0);
    ex(r + 1,  '0, 4'h0, 4'h0, 1'b1, 1'b1);
    ex(r + 21, '0, 4'h0, 4'hF, 1'b0, 1'b1);
    step(); reset = 1'b0;
    wait_until(r + 28);

    chk("queue_drained", 160'(exp_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
